// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter and sequences instruction fetch from a
//   handshaked instruction memory. Each fetch presents PC on imem_addr,
//   holds imem_req until imem_ack, latches the word into IR, then spends
//   one EXEC cycle with ir_valid=1 while the controller decides the next
//   PC (jump, increment, refetch) or halts.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : fetch watchdog of TIMEOUT_CYC cycles; expiry sets the
//                 sticky fetch_err and halts. Resume after a watchdog halt
//                 refetches the same PC.
//     undefined : FETCH waits indefinitely, fetch_err is tied to 0.
//
// Ports
//   Clk, reset_n              clock (rising edge), async active-low reset
//   IncPC, LoadPC, SelPC,     controller decision, sampled only in EXEC
//   LoadIR
//   RegVal, Imm               jump targets (SelPC: 0 = RegVal, 1 = Imm)
//   resume                    leave HALTED
//   imem_req, imem_addr       fetch request / address (= PC)
//   imem_ack, imem_rdata      memory accept / instruction word
//   IR, Opcode, ir_valid      instruction register, its top nibble, EXEC flag
//   PC, halted, fetch_err     program counter, HALTED flag, watchdog error
//
// State  | meaning
// -------+-------------------------------------------------------------
// Idle   | just out of reset; moves to Fetch on the first clock
// Fetch  | imem_req=1 at PC, waiting for imem_ack
// Exec   | IR valid for one cycle; controls choose next PC or halt
// Halted | no fetching; resume restarts

module pc_fetch_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned INSTR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               IncPC,
    input  logic               LoadPC,
    input  logic               SelPC,
    input  logic               LoadIR,
    input  logic [ADDR_W-1:0]  RegVal,
    input  logic [ADDR_W-1:0]  Imm,
    input  logic               resume,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IR,
    output logic [3:0]         Opcode,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  PC,
    output logic               halted,
    output logic               fetch_err
);

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Fetch  = 2'd1,
        Exec   = 2'd2,
        Halted = 2'd3
    } state_t;

    state_t              state, nextState;
    logic [ADDR_W-1:0]   pcReg, pcNext;
    logic [INSTR_W-1:0]  irReg, irNext;
    logic [3:0]          ctrl;
    logic                timeoutFire;
    logic                timeoutHalt;

    assign ctrl = {LoadPC, IncPC, LoadIR, SelPC};

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= Idle;
            pcReg <= RESET_PC;
            irReg <= '0;
        end else begin
            state <= nextState;
            pcReg <= pcNext;
            irReg <= irNext;
        end
    end

    always_comb begin
        nextState = state;
        pcNext    = pcReg;
        irNext    = irReg;
        case (state)
            Idle: nextState = Fetch;
            Fetch: begin
                if (imem_ack) begin
                    irNext    = imem_rdata;
                    nextState = Exec;
                end else if (timeoutFire) begin
                    nextState = Halted;
                end
            end
            Exec: begin
                // Every legal control combination is listed explicitly so that
                // any unknown bit falls into the default and halts fail-safe.
                case (ctrl)
                    4'b1000, 4'b1010, 4'b1100, 4'b1110: begin
                        pcNext    = RegVal;
                        nextState = Fetch;
                    end
                    4'b1001, 4'b1011, 4'b1101, 4'b1111: begin
                        pcNext    = Imm;
                        nextState = Fetch;
                    end
                    4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                        pcNext    = pcReg + ADDR_W'(1);
                        nextState = Fetch;
                    end
                    4'b0010, 4'b0011: nextState = Fetch;
                    4'b0000, 4'b0001: nextState = Halted;
                    default:          nextState = Halted;
                endcase
            end
            Halted: begin
                if (resume) begin
                    // A watchdog halt retries the failed address instead of skipping it.
                    pcNext    = timeoutHalt ? pcReg : pcReg + ADDR_W'(1);
                    nextState = Fetch;
                end
            end
            default: nextState = Halted;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] wdCnt;
    logic            errReg;
    logic            timeoutHaltReg;

    // Down-counter loaded on entry to Fetch; terminal count with no ack
    // marks the TIMEOUT_CYC-th waiting cycle.
    assign timeoutFire = (state == Fetch) && !imem_ack && (wdCnt == '0);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wdCnt          <= CntLoad;
            errReg         <= 1'b0;
            timeoutHaltReg <= 1'b0;
        end else begin
            if ((nextState == Fetch) && (state != Fetch)) begin
                wdCnt <= CntLoad;
            end else if ((state == Fetch) && (wdCnt != '0)) begin
                wdCnt <= wdCnt - CntW'(1);
            end
            if (timeoutFire) begin
                errReg <= 1'b1;
            end
            if (timeoutFire) begin
                timeoutHaltReg <= 1'b1;
            end else if ((state == Halted) && resume) begin
                timeoutHaltReg <= 1'b0;
            end
        end
    end

    assign timeoutHalt = timeoutHaltReg;
    assign fetch_err   = errReg;
`else
    assign timeoutFire = 1'b0;
    assign timeoutHalt = 1'b0;
    assign fetch_err   = 1'b0;

    // Watchdog absent: TIMEOUT_CYC has no effect in this build.
    if (TIMEOUT_CYC < 1) begin : gTimeoutUnused
    end
`endif

    assign imem_req  = (state == Fetch);
    assign imem_addr = pcReg;
    assign ir_valid  = (state == Exec);
    assign halted    = (state == Halted);
    assign PC        = pcReg;
    assign IR        = irReg;
    assign Opcode    = irReg[INSTR_W-1 -: 4];

endmodule
